dpram64_arb: RTL and testbench



---
 rtl/dpram64_arb.sv | 125 ++++++++++++
 tb/tb_dpram64_arb.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram64_arb.sv
// Two-requester front end for a 64-bit byte-write dual-port RAM. The write and read
// ports each have their own round-robin arbiter. Read data returns one cycle later.
module dpram64_arb #(
  parameter int SIZE = 65536,
  parameter bit FWD  = 1'b1,
  localparam int AW  = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          i_req0_valid,
  output logic          o_req0_ready,
  input  logic [7:0]    i_req0_we,
  input  logic [AW-1:0] i_req0_addr,
  input  logic [63:0]   i_req0_wdata,
  output logic          o_rsp0_valid,
  output logic [63:0]   o_rsp0_rdata,

  input  logic          i_req1_valid,
  output logic          o_req1_ready,
  input  logic [7:0]    i_req1_we,
  input  logic [AW-1:0] i_req1_addr,
  input  logic [63:0]   i_req1_wdata,
  output logic          o_rsp1_valid,
  output logic [63:0]   o_rsp1_rdata,

  output logic [7:0]    o_ram_we,
  output logic [63:0]   o_ram_din,
  output logic [AW-1:0] o_ram_waddr,
  output logic [AW-1:0] o_ram_raddr,
  input  logic [63:0]   i_ram_dout
);

  function automatic logic [63:0] merge_bytes(input logic [63:0] ram,
                                              input logic [63:0] wd,
                                              input logic [7:0]  we);
    logic [63:0] res;
    res = ram;
    for (int b = 0; b < 8; b++) begin
      if (we[b]) res[8*b +: 8] = wd[8*b +: 8];
    end
    return res;
  endfunction

  logic wr0, wr1, rd0, rd1;
  logic wgnt0, wgnt1, rgnt0, rgnt1;
  logic wr_last, rd_last;
  logic fwd_hit;

  logic        vld_p1;
  logic        rd_id_p1;
  logic [7:0]  fwd_we_p1;
  logic [63:0] fwd_wdata_p1;
  logic [63:0] rdata_p1;

  assign wr0 = i_req0_valid && (i_req0_we != 8'd0);
  assign wr1 = i_req1_valid && (i_req1_we != 8'd0);
  assign rd0 = i_req0_valid && (i_req0_we == 8'd0);
  assign rd1 = i_req1_valid && (i_req1_we == 8'd0);

  always_comb begin
    wgnt0 = 1'b0;
    wgnt1 = 1'b0;
    rgnt0 = 1'b0;
    rgnt1 = 1'b0;
    if (rst_n) begin
      wgnt0 = wr0 && (!wr1 || wr_last);
      wgnt1 = wr1 && (!wr0 || !wr_last);
      rgnt0 = rd0 && (!rd1 || rd_last);
      rgnt1 = rd1 && (!rd0 || !rd_last);
    end
  end

  assign o_req0_ready = wgnt0 | rgnt0;
  assign o_req1_ready = wgnt1 | rgnt1;

  always_comb begin
    o_ram_we    = 8'd0;
    o_ram_din   = i_req0_wdata;
    o_ram_waddr = i_req0_addr;
    if (wgnt1) begin
      o_ram_we    = i_req1_we;
      o_ram_din   = i_req1_wdata;
      o_ram_waddr = i_req1_addr;
    end else if (wgnt0) begin
      o_ram_we    = i_req0_we;
    end
  end

  assign o_ram_raddr = rgnt1 ? i_req1_addr : i_req0_addr;

  // Same-word read and write in one cycle: the RAM returns old data, so keep the write bytes.
  assign fwd_hit = FWD && (wgnt0 | wgnt1) && (rgnt0 | rgnt1) &&
                   (o_ram_waddr[AW-1:3] == o_ram_raddr[AW-1:3]);

  // Stage p0 -> p1: grant cycle into response cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_last      <= 1'b1;
      rd_last      <= 1'b1;
      vld_p1       <= 1'b0;
      rd_id_p1     <= 1'b0;
      fwd_we_p1    <= 8'd0;
      fwd_wdata_p1 <= 64'd0;
    end else begin
      if (wr0 && wr1) wr_last <= wgnt1;
      if (rd0 && rd1) rd_last <= rgnt1;
      vld_p1   <= rgnt0 | rgnt1;
      rd_id_p1 <= rgnt1;
      if (fwd_hit) begin
        fwd_we_p1    <= o_ram_we;
        fwd_wdata_p1 <= o_ram_din;
      end else begin
        fwd_we_p1    <= 8'd0;
      end
    end
  end

  assign rdata_p1     = merge_bytes(i_ram_dout, fwd_wdata_p1, fwd_we_p1);
  assign o_rsp0_valid = vld_p1 && !rd_id_p1;
  assign o_rsp1_valid = vld_p1 &&  rd_id_p1;
  assign o_rsp0_rdata = rdata_p1;
  assign o_rsp1_rdata = rdata_p1;

endmodule

// File: tb/tb_dpram64_arb.sv
// Bench for dpram64_arb: two instances (FWD=1 and FWD=0) on shared requests, each with
// its own RAM model, checked against a transaction-level reference of the arbiter and memory.
module tb_dpram64_arb;
  localparam int SIZE = 65536;
  localparam int AW   = 16;
  localparam int NW   = SIZE / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          v0, v1;
  logic [7:0]    we0, we1;
  logic [AW-1:0] a0, a1;
  logic [63:0]   d0, d1;

  logic          r0_f, r1_f, rv0_f, rv1_f;
  logic [63:0]   rd0_f, rd1_f, din_f, dout_f;
  logic [7:0]    ram_we_f;
  logic [AW-1:0] waddr_f, raddr_f;

  logic          r0_n, r1_n, rv0_n, rv1_n;
  logic [63:0]   rd0_n, rd1_n, din_n, dout_n;
  logic [7:0]    ram_we_n;
  logic [AW-1:0] waddr_n, raddr_n;

  dpram64_arb #(.SIZE(SIZE), .FWD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req0_valid(v0), .o_req0_ready(r0_f), .i_req0_we(we0), .i_req0_addr(a0),
    .i_req0_wdata(d0), .o_rsp0_valid(rv0_f), .o_rsp0_rdata(rd0_f),
    .i_req1_valid(v1), .o_req1_ready(r1_f), .i_req1_we(we1), .i_req1_addr(a1),
    .i_req1_wdata(d1), .o_rsp1_valid(rv1_f), .o_rsp1_rdata(rd1_f),
    .o_ram_we(ram_we_f), .o_ram_din(din_f), .o_ram_waddr(waddr_f),
    .o_ram_raddr(raddr_f), .i_ram_dout(dout_f)
  );

  dpram64_arb #(.SIZE(SIZE), .FWD(1'b0)) dut_nf (
    .clk(clk), .rst_n(rst_n),
    .i_req0_valid(v0), .o_req0_ready(r0_n), .i_req0_we(we0), .i_req0_addr(a0),
    .i_req0_wdata(d0), .o_rsp0_valid(rv0_n), .o_rsp0_rdata(rd0_n),
    .i_req1_valid(v1), .o_req1_ready(r1_n), .i_req1_we(we1), .i_req1_addr(a1),
    .i_req1_wdata(d1), .o_rsp1_valid(rv1_n), .o_rsp1_rdata(rd1_n),
    .o_ram_we(ram_we_n), .o_ram_din(din_n), .o_ram_waddr(waddr_n),
    .o_ram_raddr(raddr_n), .i_ram_dout(dout_n)
  );

  // Byte-write RAMs with a registered read port, old data on same-cycle collision
  logic [63:0] mem_f [NW];
  logic [63:0] mem_n [NW];
  initial begin
    for (int i = 0; i < NW; i++) begin
      mem_f[i] = 64'd0;
      mem_n[i] = 64'd0;
    end
    dout_f = 64'd0;
    dout_n = 64'd0;
    forever begin
      @(posedge clk);
      dout_f <= mem_f[raddr_f[AW-1:3]];
      dout_n <= mem_n[raddr_n[AW-1:3]];
      for (int b = 0; b < 8; b++) begin
        if (ram_we_f[b]) mem_f[waddr_f[AW-1:3]][8*b +: 8] = din_f[8*b +: 8];
        if (ram_we_n[b]) mem_n[waddr_n[AW-1:3]][8*b +: 8] = din_n[8*b +: 8];
      end
    end
  end

  // Reference state
  logic [63:0] ref_mem [NW];
  bit          m_wr_last, m_rd_last;
  bit          exp_vld, exp_id;
  logic [63:0] exp_f, exp_n;
  bit          last_g0, last_g1;
  bit          s_r0, s_r1;
  int          checks, failures;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic setreq(input int n, input bit v, input logic [7:0] we, input int a,
                        input logic [63:0] d);
    if (n == 0) begin
      v0 = v; we0 = we; a0 = AW'(a); d0 = d;
    end else begin
      v1 = v; we1 = we; a1 = AW'(a); d1 = d;
    end
  endtask

  // One request cycle: predict grants and RAM port values, then check the response next cycle.
  task automatic step();
    int            wwin, rwin;
    bit            w0, w1, q0, q1;
    logic [7:0]    xwe;
    logic [63:0]   xdin, old;
    logic [AW-1:0] xwa, xra;
    #1;
    w0 = v0 && (we0 != 8'd0);
    w1 = v1 && (we1 != 8'd0);
    q0 = v0 && (we0 == 8'd0);
    q1 = v1 && (we1 == 8'd0);
    wwin = -1;
    if (w0 && w1) begin
      wwin = m_wr_last ? 0 : 1;
      m_wr_last = (wwin == 1);
    end else if (w0) wwin = 0;
    else if (w1) wwin = 1;
    rwin = -1;
    if (q0 && q1) begin
      rwin = m_rd_last ? 0 : 1;
      m_rd_last = (rwin == 1);
    end else if (q0) rwin = 0;
    else if (q1) rwin = 1;
    last_g0 = (wwin == 0) || (rwin == 0);
    last_g1 = (wwin == 1) || (rwin == 1);
    xwe  = (wwin == 1) ? we1 : (wwin == 0) ? we0 : 8'd0;
    xdin = (wwin == 1) ? d1 : d0;
    xwa  = (wwin == 1) ? a1 : a0;
    xra  = (rwin == 1) ? a1 : a0;
    s_r0 = r0_f;
    s_r1 = r1_f;
    chk("ready0", 64'(r0_f), 64'(last_g0));
    chk("ready1", 64'(r1_f), 64'(last_g1));
    chk("ready0_nf", 64'(r0_n), 64'(last_g0));
    chk("ready1_nf", 64'(r1_n), 64'(last_g1));
    chk("ram_we", 64'(ram_we_f), 64'(xwe));
    chk("ram_din", din_f, xdin);
    chk("ram_waddr", 64'(waddr_f), 64'(xwa));
    chk("ram_raddr", 64'(raddr_f), 64'(xra));
    exp_vld = (rwin >= 0);
    exp_id  = (rwin == 1);
    if (exp_vld) begin
      old   = ref_mem[xra[AW-1:3]];
      exp_n = old;
      exp_f = old;
      if (wwin >= 0 && xwa[AW-1:3] == xra[AW-1:3])
        for (int b = 0; b < 8; b++) if (xwe[b]) exp_f[8*b +: 8] = xdin[8*b +: 8];
    end
    if (wwin >= 0)
      for (int b = 0; b < 8; b++) if (xwe[b]) ref_mem[xwa[AW-1:3]][8*b +: 8] = xdin[8*b +: 8];
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rsp0_vld", 64'(rv0_f), 64'(exp_vld && !exp_id));
    chk("rsp1_vld", 64'(rv1_f), 64'(exp_vld && exp_id));
    chk("rsp0_vld_nf", 64'(rv0_n), 64'(exp_vld && !exp_id));
    chk("rsp1_vld_nf", 64'(rv1_n), 64'(exp_vld && exp_id));
    if (exp_vld && exp_id) begin
      chk("rsp1_data", rd1_f, exp_f);
      chk("rsp1_data_nf", rd1_n, exp_n);
    end else if (exp_vld) begin
      chk("rsp0_data", rd0_f, exp_f);
      chk("rsp0_data_nf", rd0_n, exp_n);
    end
  endtask

  localparam logic [63:0] DA = 64'hA0A1A2A3A4A5A6A7;
  localparam logic [63:0] DB = 64'hB0B1B2B3B4B5B6B7;
  localparam logic [63:0] DC = 64'hC0C1C2C3C4C5C6C7;

  initial begin
    bit h0, h1;
    checks = 0;
    failures = 0;
    for (int i = 0; i < NW; i++) ref_mem[i] = 64'd0;
    m_wr_last = 1'b1;
    m_rd_last = 1'b1;
    exp_vld   = 1'b0;
    rst_n = 1'b0;
    setreq(0, 1'b1, 8'hFF, 'h40, 64'h1);
    setreq(1, 1'b1, 8'h00, 'h48, 64'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rsp0_vld", 64'(rv0_f), 64'd0);
    chk("reset_rsp1_vld", 64'(rv1_f), 64'd0);
    chk("reset_ready0", 64'(r0_f), 64'd0);
    chk("reset_ready1", 64'(r1_f), 64'd0);
    chk("reset_ram_we", 64'(ram_we_f), 64'd0);
    setreq(0, 1'b0, 8'h00, 0, 64'd0);
    setreq(1, 1'b0, 8'h00, 0, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Single read after preloading word 0x10
    setreq(0, 1'b1, 8'hFF, 'h80, 64'h1122334455667788);
    step();
    setreq(0, 1'b1, 8'h00, 'h80, 64'd0);
    step();
    chk("single_read_data", rd0_f, 64'h1122334455667788);
    chk("single_read_ready", 64'(s_r0), 64'd1);

    // Write-port conflict alternates starting with requester 0
    setreq(0, 1'b1, 8'hFF, 'h00, DA);
    setreq(1, 1'b1, 8'hFF, 'h08, DB);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("conflict_ready0", 64'(s_r0), 64'(i % 2 == 0));
      chk("conflict_onehot", 64'(s_r0 ^ s_r1), 64'd1);
    end

    // Concurrent write and read
    setreq(0, 1'b1, 8'hFF, 'h10, DC);
    setreq(1, 1'b1, 8'h00, 'h20, 64'd0);
    step();
    chk("concurrent_both_ready", 64'(s_r0 & s_r1), 64'd1);
    setreq(1, 1'b0, 8'h00, 0, 64'd0);
    setreq(0, 1'b1, 8'h00, 'h13, 64'd0);
    step();
    chk("concurrent_readback", rd0_f, DC);

    // Forwarding of a partial write into a same-cycle read of word 4
    setreq(0, 1'b1, 8'h0F, 'h20, 64'hAAAAAAAABBBBBBBB);
    setreq(1, 1'b1, 8'h00, 'h20, 64'd0);
    step();
    chk("fwd_merge", rd1_f, 64'h00000000BBBBBBBB);
    chk("fwd_off_old", rd1_n, 64'd0);

    // Read streaming on requester 1
    setreq(0, 1'b0, 8'h00, 0, 64'd0);
    setreq(1, 1'b1, 8'h00, 'h00, 64'd0);
    step();
    chk("stream0", rd1_f, DA);
    setreq(1, 1'b1, 8'h00, 'h08, 64'd0);
    step();
    chk("stream1", rd1_f, DB);
    setreq(1, 1'b1, 8'h00, 'h10, 64'd0);
    step();
    chk("stream2", rd1_f, DC);

    // Randomized traffic with held requests
    h0 = 1'b0;
    h1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!h0) begin
        if ($urandom_range(0, 3) != 0) begin
          v0  = 1'b1;
          we0 = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
          a0  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 63));
          d0  = {$urandom, $urandom};
          h0  = 1'b1;
        end else v0 = 1'b0;
      end
      if (!h1) begin
        if ($urandom_range(0, 3) != 0) begin
          v1  = 1'b1;
          we1 = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
          a1  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 63));
          d1  = {$urandom, $urandom};
          h1  = 1'b1;
        end else v1 = 1'b0;
      end
      step();
      if (last_g0) h0 = 1'b0;
      if (last_g1) h1 = 1'b0;
    end

    // Asynchronous reset between a read grant and its response
    setreq(0, 1'b0, 8'h00, 0, 64'd0);
    setreq(1, 1'b1, 8'h00, 'h08, 64'd0);
    #1;
    @(posedge clk);
    #2;
    chk("pre_reset_rsp1", 64'(rv1_f), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rsp1_drop", 64'(rv1_f), 64'd0);
    chk("async_rsp1_drop_nf", 64'(rv1_n), 64'd0);
    chk("async_rsp0_low", 64'(rv0_f), 64'd0);
    setreq(0, 1'b1, 8'hFF, 'h30, 64'd5);
    #1;
    chk("in_reset_ready0", 64'(r0_f), 64'd0);
    chk("in_reset_ready1", 64'(r1_f), 64'd0);
    chk("in_reset_ram_we", 64'(ram_we_f), 64'd0);
    setreq(0, 1'b0, 8'h00, 0, 64'd0);
    setreq(1, 1'b0, 8'h00, 0, 64'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    m_wr_last = 1'b1;
    m_rd_last = 1'b1;
    exp_vld   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("post_reset_no_rsp", 64'(rv0_f | rv1_f | rv0_n | rv1_n), 64'd0);
    end
    setreq(0, 1'b1, 8'hFF, 'h30, 64'h0123456789ABCDEF);
    setreq(1, 1'b1, 8'hFF, 'h38, 64'hFEDCBA9876543210);
    step();
    chk("post_reset_wr_win0", 64'(s_r0), 64'd1);
    chk("post_reset_wr_lose1", 64'(s_r1), 64'd0);
    setreq(0, 1'b1, 8'h00, 'h30, 64'd0);
    setreq(1, 1'b1, 8'h00, 'h38, 64'd0);
    step();
    chk("post_reset_rd_win0", 64'(s_r0), 64'd1);
    chk("post_reset_rd_data", rd0_f, 64'h0123456789ABCDEF);
    setreq(0, 1'b0, 8'h00, 0, 64'd0);
    setreq(1, 1'b0, 8'h00, 0, 64'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
